// File: rtl/nes_pad_poller.sv
// NES game pad poller: strobes the pad at a fixed rate, shifts in the 8 button
// bits and publishes them as an active-high byte with an optional change interrupt.
module nes_pad_poller #(
    parameter int POLL_CYCLES   = 416667,
    parameter int LATCH_CYCLES  = 300,
    parameter int HALF_CYCLES   = 150,
    parameter bit INT_ON_CHANGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       data_in,
    output logic       latch_out,
    output logic       clk_out,
    output logic [7:0] controller_data,
    output logic       int_out_c,
    output logic       busy
);

    localparam int POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETTLE = 3'd2,
        S_CLK_HI = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [POLL_W-1:0]  r_poll_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_latch;
    logic               r_clk;
    logic               r_int;
    logic               r_busy;

    logic               w_tick;
    logic [7:0]         w_shift_next;
    logic               w_changed;

    assign w_tick    = (r_poll_cnt == POLL_LAST);
    assign w_changed = (w_shift_next != r_data);

    // Shift register image including the bit captured on this SETTLE cycle.
    always_comb begin
        w_shift_next            = r_shift;
        w_shift_next[r_bit_idx] = ~r_sync2;
    end

    // Free-running poll counter, independent of state and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_cnt <= '0;
        end else if (w_tick) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + POLL_W'(1);
        end
    end

    // Two-flop synchronizer; idles high (released button) out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
        end
    end

    // Frame sequencer; outputs are set on the edge entering each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_latch   <= 1'b0;
            r_clk     <= 1'b0;
            r_int     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_int <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && enable) begin
                        r_state   <= S_LATCH;
                        r_phase   <= '0;
                        r_bit_idx <= 3'd0;
                        r_latch   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_phase == LATCH_LAST) begin
                        r_state <= S_SETTLE;
                        r_phase <= '0;
                        r_latch <= 1'b0;
                    end else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_phase == HALF_LAST) begin
                        r_phase <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit_idx == 3'd7) begin
                            // Publish here so the byte and the pulse share the DONE cycle.
                            r_state <= S_DONE;
                            r_data  <= w_shift_next;
                            r_int   <= (!INT_ON_CHANGE) || w_changed;
                        end else begin
                            r_state <= S_CLK_HI;
                            r_clk   <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                S_CLK_HI: begin
                    if (r_phase == HALF_LAST) begin
                        r_state   <= S_SETTLE;
                        r_phase   <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_clk     <= 1'b0;
                    end else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                    r_latch <= 1'b0;
                    r_clk   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign latch_out       = r_latch;
    assign clk_out         = r_clk;
    assign controller_data = r_data;
    assign int_out_c       = r_int;
    assign busy            = r_busy;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Self-checking bench: two pollers (change / every-poll interrupt) fed by pad
// models, checked each cycle against a frame-position model plus literal checks.
module tb_nes_pad_poller;

    localparam int POLL  = 4000;
    localparam int LAT   = 12;
    localparam int HALF  = 6;
    localparam int FRAME = LAT + 15*HALF + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enable;
    logic       noise_en;
    logic       noise = 1'b0;
    logic [7:0] pad_pat_a;
    logic [7:0] pad_pat_b = 8'h10;

    logic       data_in_a, latch_a, clk_out_a, int_a, busy_a;
    logic [7:0] data_a;
    logic       data_in_b, latch_b, clk_out_b, int_b, busy_b;
    logic [7:0] data_b;

    nes_pad_poller #(.POLL_CYCLES(POLL), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                     .INT_ON_CHANGE(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in_a),
        .latch_out(latch_a), .clk_out(clk_out_a), .controller_data(data_a),
        .int_out_c(int_a), .busy(busy_a));

    nes_pad_poller #(.POLL_CYCLES(POLL), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
                     .INT_ON_CHANGE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in_b),
        .latch_out(latch_b), .clk_out(clk_out_b), .controller_data(data_b),
        .int_out_c(int_b), .busy(busy_b));

    // Pad models: latch reloads, each clk_out rise presents the next button (active-low).
    int idx_a = 0;
    int idx_b = 0;
    always @(posedge latch_a) idx_a = 0;
    always @(posedge clk_out_a) idx_a = idx_a + 1;
    always @(posedge latch_b) idx_b = 0;
    always @(posedge clk_out_b) idx_b = idx_b + 1;

    logic pad_val_a, pad_val_b;
    assign pad_val_a = (idx_a < 8) ? ~pad_pat_a[idx_a[2:0]] : 1'b1;
    assign pad_val_b = (idx_b < 8) ? ~pad_pat_b[idx_b[2:0]] : 1'b1;

    // Asynchronous noise, only visible on the line while clk_out is high.
    always #3 noise = ~noise;
    assign data_in_a = (noise_en && clk_out_a) ? noise : pad_val_a;
    assign data_in_b = pad_val_b;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: frame position since the accepted tick, derived from the frame shape.
    int         m_cnt [2] = '{0, 0};
    int         m_pos [2] = '{-1, -1};
    logic [7:0] m_data[2] = '{8'h00, 8'h00};
    logic [7:0] m_byte[2] = '{8'h00, 8'h00};
    logic       m_int [2] = '{1'b0, 1'b0};
    logic       ioc   [2] = '{1'b1, 1'b0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int         np;
            logic       tk;
            logic [7:0] nb;
            if (rst) begin
                m_cnt[d]  <= 0;
                m_pos[d]  <= -1;
                m_data[d] <= 8'h00;
                m_int[d]  <= 1'b0;
            end else begin
                tk = (m_cnt[d] == POLL-1);
                np = m_pos[d];
                nb = m_byte[d];
                if (np >= 0) np = (np == FRAME-1) ? -1 : np + 1;
                else if (tk && enable) begin
                    np = 0;
                    nb = (d == 0) ? pad_pat_a : pad_pat_b;
                end
                m_cnt[d]  <= tk ? 0 : m_cnt[d] + 1;
                m_pos[d]  <= np;
                m_byte[d] <= nb;
                if (np == FRAME-1) begin
                    m_int[d]  <= !ioc[d] || (nb != m_data[d]);
                    m_data[d] <= nb;
                end else begin
                    m_int[d] <= 1'b0;
                end
            end
        end
    end

    function automatic logic exp_clk(input int pos);
        int q;
        q = pos - LAT;
        return (pos >= 0) && (q >= 0) && (q < 15*HALF) && (((q / HALF) % 2) == 1);
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("A.latch_out", 32'(latch_a), 32'((m_pos[0] >= 0) && (m_pos[0] < LAT)));
        check("A.clk_out",   32'(clk_out_a), 32'(exp_clk(m_pos[0])));
        check("A.busy",      32'(busy_a), 32'(m_pos[0] >= 0));
        check("A.data",      32'(data_a), 32'(m_data[0]));
        check("A.int",       32'(int_a), 32'(m_int[0]));
        check("B.latch_out", 32'(latch_b), 32'((m_pos[1] >= 0) && (m_pos[1] < LAT)));
        check("B.clk_out",   32'(clk_out_b), 32'(exp_clk(m_pos[1])));
        check("B.busy",      32'(busy_b), 32'(m_pos[1] >= 0));
        check("B.data",      32'(data_b), 32'(m_data[1]));
        check("B.int",       32'(int_b), 32'(m_int[1]));
    end

    int ia_cnt = 0;
    int ib_cnt = 0;
    always @(negedge clk) begin
        if (int_a) ia_cnt <= ia_cnt + 1;
        if (int_b) ib_cnt <= ib_cnt + 1;
    end

    task automatic wait_latch(input string name, output int k);
        k = 0;
        for (int i = 1; i <= POLL + 200; i++) begin
            @(negedge clk);
            if (latch_a) begin
                k = i;
                break;
            end
        end
        if (k == 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_int(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < POLL + 200; i++) begin
            @(negedge clk);
            if (int_a) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_latch(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (latch_a) c = c + 1;
        end
    endtask

    int k, lat_n, clk_hi_n, rise_n, busy_n, c, s_a, s_b;
    logic prev_clk;

    initial begin
        rst = 1'b1; enable = 1'b0; noise_en = 1'b0; pad_pat_a = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_busy", 32'(busy_a), 32'h0);
        rst = 1'b0; enable = 1'b1;

        // Unplugged pad: frame shape and zero data, no interrupt in change mode.
        s_a = ia_cnt; s_b = ib_cnt;
        wait_latch("first_latch", k);
        check("first_latch_cycle", 32'(k), 32'(POLL));
        lat_n = 0; clk_hi_n = 0; rise_n = 0; busy_n = 0; prev_clk = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            if (latch_a) lat_n++;
            if (clk_out_a) clk_hi_n++;
            if (clk_out_a && !prev_clk) rise_n++;
            if (busy_a) busy_n++;
            prev_clk = clk_out_a;
            @(negedge clk);
        end
        check("latch_width", 32'(lat_n), 32'(LAT));
        check("clk_pulses", 32'(rise_n), 32'd7);
        check("clk_high_total", 32'(clk_hi_n), 32'(7*HALF));
        check("busy_len", 32'(busy_n), 32'd103);
        check("unplugged_data", 32'(data_a), 32'h00);
        check("unplugged_no_int", 32'(ia_cnt - s_a), 32'd0);
        check("B_first_data", 32'(data_b), 32'h10);
        check("B_first_int", 32'(ib_cnt - s_b), 32'd1);

        // 0xA5 pressed: publish with a single pulse.
        pad_pat_a = 8'hA5; s_b = ib_cnt;
        wait_int("a5_int");
        check("a5_data", 32'(data_a), 32'hA5);
        @(negedge clk);
        check("a5_single_pulse", 32'(int_a), 32'd0);
        check("B_int_per_poll", 32'(ib_cnt - s_b), 32'd1);

        // Same pattern again: no interrupt.
        s_a = ia_cnt; s_b = ib_cnt;
        repeat (POLL + 200) @(negedge clk);
        check("same_no_int", 32'(ia_cnt - s_a), 32'd0);
        check("same_data", 32'(data_a), 32'hA5);
        check("B_int_per_poll2", 32'(ib_cnt - s_b), 32'd1);

        // Change to 0x81.
        pad_pat_a = 8'h81;
        wait_int("81_int");
        check("81_data", 32'(data_a), 32'h81);

        // Enable low across a tick: nothing happens.
        @(negedge clk);
        enable = 1'b0; s_b = ib_cnt;
        count_latch(POLL + 200, c);
        check("disabled_no_latch", 32'(c), 32'd0);
        check("disabled_data", 32'(data_a), 32'h81);
        check("disabled_B_no_int", 32'(ib_cnt - s_b), 32'd0);

        // Enable dropped 20 clocks into a frame: frame still publishes.
        enable = 1'b1; pad_pat_a = 8'h3C;
        wait_latch("en_drop_latch", k);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_int("en_drop_int");
        check("en_drop_data", 32'(data_a), 32'h3C);
        count_latch(POLL + 200, c);
        check("en_drop_next_tick_ignored", 32'(c), 32'd0);

        // Noise on data_in only while clk_out is high.
        enable = 1'b1; pad_pat_a = 8'h5A; noise_en = 1'b1;
        wait_int("noise_int");
        check("noise_data", 32'(data_a), 32'h5A);
        @(negedge clk);
        noise_en = 1'b0;

        // Reset pulse mid-CLK_HI aborts the frame.
        pad_pat_a = 8'h66;
        wait_latch("rst_frame_latch", k);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (clk_out_a) break;
        end
        check("rst_in_clk_hi", 32'(clk_out_a), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_latch", 32'(latch_a), 32'd0);
        check("midrst_clk", 32'(clk_out_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'h00);
        check("midrst_int", 32'(int_a), 32'd0);
        rst = 1'b0;
        wait_latch("post_rst_latch", k);
        check("post_rst_latch_cycle", 32'(k), 32'(POLL));
        wait_int("post_rst_int");
        check("post_rst_data", 32'(data_a), 32'h66);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
